// File: rtl/safety_monitor_pkg.sv
// Shared constants and types for the N-channel over-current safety monitor.
// Status-word layout, default clear address and scan FSM encoding live here.
package safety_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    localparam logic [15:0] CLR_ADDR_DEFAULT = 16'h0009;
    localparam int          OVERRUN_BIT      = 31;
    localparam int          CNT_W            = 8;

    // Offset-binary zero point for a word of width w.
    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/safety_cmp_stage.sv
// Two-stage magnitude / limit compare, time-shared across channels.
// Stage 1 registers both magnitudes; stage 2 is the combinational limit check.
module safety_cmp_stage
    import safety_monitor_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] TOL    = 16'h0100,
    parameter int                CHAN_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [CHAN_W-1:0] issue_chan,
    input  logic [DATA_W-1:0] fb,
    input  logic [DATA_W-1:0] cmd,
    output logic              retire_valid,
    output logic [CHAN_W-1:0] retire_chan,
    output logic              fault
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    // Code 0 yields exactly MID, which still fits in DATA_W bits.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
        return (x >= MID) ? (x - MID) : (MID - x);
    endfunction

    logic [DATA_W-1:0] fb_mag_reg;
    logic [DATA_W-1:0] cmd_mag_reg;
    logic              valid_reg;
    logic [CHAN_W-1:0] chan_reg;
    logic [DATA_W+1:0] limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_mag_reg  <= '0;
            cmd_mag_reg <= '0;
            valid_reg   <= 1'b0;
            chan_reg    <= '0;
        end else begin
            valid_reg <= issue_valid;
            if (issue_valid) begin
                fb_mag_reg  <= mag(fb);
                cmd_mag_reg <= mag(cmd);
                chan_reg    <= issue_chan;
            end
        end
    end

    // Two guard bits keep 2*cmd_mag + TOL from wrapping.
    assign limit        = {1'b0, cmd_mag_reg, 1'b0} + {2'b00, TOL};
    assign fault        = valid_reg && ({2'b00, fb_mag_reg} > limit);
    assign retire_valid = valid_reg;
    assign retire_chan  = chan_reg;

endmodule

// File: rtl/safety_monitor.sv
// N-channel over-current monitor: snapshot on strobe, serial scan through one
// shared compare pipeline, per-channel debounce and latched amp disables.
module safety_monitor
    import safety_monitor_pkg::*;
#(
    parameter int                NUM_CHAN   = 4,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] TOL        = 16'h0100,
    parameter int                TRIP_COUNT = 4,
    parameter logic [15:0]       CLR_ADDR   = CLR_ADDR_DEFAULT
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [NUM_CHAN*DATA_W-1:0] cur_fb,
    input  logic [NUM_CHAN*DATA_W-1:0] cur_cmd,
    input  logic                       reg_wen,
    input  logic [15:0]                reg_waddr,
    input  logic [31:0]                reg_wdata,
    output logic [31:0]                reg_rdata,
    output logic [NUM_CHAN-1:0]        amp_disable,
    output logic                       scan_done,
    output logic                       overrun
);

    localparam int               IDX_W    = idx_width(NUM_CHAN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHAN - 1);
    localparam logic [CNT_W-1:0] TRIP     = CNT_W'(TRIP_COUNT);

    scan_state_t state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic capture, issue, scan_done_next, strobe_overrun;
    logic scan_done_reg, overrun_reg, overrun_next;
    logic clr_write;

    logic [NUM_CHAN-1:0][DATA_W-1:0] snap_fb_reg;
    logic [NUM_CHAN-1:0][DATA_W-1:0] snap_cmd_reg;

    logic             retire_valid;
    logic [IDX_W-1:0] retire_chan;
    logic             fault;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        capture        = 1'b0;
        issue          = 1'b0;
        scan_done_next = 1'b0;
        strobe_overrun = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sample_valid) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                issue          = 1'b1;
                strobe_overrun = sample_valid;
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                strobe_overrun = sample_valid;
                scan_done_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign clr_write    = reg_wen && (reg_waddr == CLR_ADDR);
    // A new overrun in the same cycle as its clear keeps the flag set.
    assign overrun_next = (overrun_reg && !(clr_write && reg_wdata[OVERRUN_BIT])) || strobe_overrun;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            snap_fb_reg   <= '0;
            snap_cmd_reg  <= '0;
            scan_done_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            scan_done_reg <= scan_done_next;
            overrun_reg   <= overrun_next;
            if (capture) begin
                snap_fb_reg  <= cur_fb;
                snap_cmd_reg <= cur_cmd;
            end
        end
    end

    safety_cmp_stage #(
        .DATA_W (DATA_W),
        .TOL    (TOL),
        .CHAN_W (IDX_W)
    ) u_cmp (
        .clk          (sysclk),
        .reset        (reset),
        .issue_valid  (issue),
        .issue_chan   (idx_reg),
        .fb           (snap_fb_reg[idx_reg]),
        .cmd          (snap_cmd_reg[idx_reg]),
        .retire_valid (retire_valid),
        .retire_chan  (retire_chan),
        .fault        (fault)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             dis_reg, dis_next;
            logic             hit, trip, clr;

            always_comb begin
                hit      = retire_valid && (retire_chan == IDX_W'(gi));
                clr      = clr_write && reg_wdata[gi];
                cnt_next = cnt_reg;
                dis_next = dis_reg;
                trip     = 1'b0;
                if (hit) begin
                    if (fault) begin
                        if (cnt_reg < TRIP) begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                        trip = (cnt_next == TRIP);
                    end else begin
                        cnt_next = '0;
                    end
                end
                // Fail-safe: a trip in the same cycle overrides a clear.
                if (clr && !trip) begin
                    cnt_next = '0;
                    dis_next = 1'b0;
                end
                if (trip) begin
                    dis_next = 1'b1;
                end
            end

            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                    dis_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    dis_reg <= dis_next;
                end
            end

            assign amp_disable[gi] = dis_reg;
        end
    endgenerate

    always_comb begin
        reg_rdata                 = '0;
        reg_rdata[NUM_CHAN-1:0]   = amp_disable;
        reg_rdata[OVERRUN_BIT]    = overrun_reg;
    end

    assign scan_done = scan_done_reg;
    assign overrun   = overrun_reg;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[OVERRUN_BIT-1:NUM_CHAN];

endmodule

// File: tb/tb_safety_monitor.sv
// Directed bench for safety_monitor: a cycle-scheduled behavioural model is
// compared every cycle, plus hand-computed checks for each scenario.
module tb_safety_monitor;

    localparam int          N    = 4;
    localparam int          DW   = 16;
    localparam logic [15:0] TOLV = 16'h0100;
    localparam int          TRIP = 4;
    localparam logic [15:0] CLR  = 16'h0009;

    logic            sysclk = 1'b0;
    logic            reset = 1'b0;
    logic            sample_valid = 1'b0;
    logic            reg_wen = 1'b0;
    logic [N*DW-1:0] cur_fb = '0;
    logic [N*DW-1:0] cur_cmd = '0;
    logic [15:0]     reg_waddr = '0;
    logic [31:0]     reg_wdata = '0;
    logic [31:0]     reg_rdata;
    logic [N-1:0]    amp_disable;
    logic            scan_done;
    logic            overrun;

    int total = 0;
    int bad = 0;

    safety_monitor #(
        .NUM_CHAN(N), .DATA_W(DW), .TOL(TOLV), .TRIP_COUNT(TRIP), .CLR_ADDR(CLR)
    ) dut (
        .sysclk(sysclk), .reset(reset), .sample_valid(sample_valid),
        .cur_fb(cur_fb), .cur_cmd(cur_cmd),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .amp_disable(amp_disable),
        .scan_done(scan_done), .overrun(overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: a sample accepted at edge c has channel k judged at edge c+2+k,
    // scan_done raised at edge c+N+1; strobes at edges c+1..c+N+1 are overruns.
    int           m_cnt [N];
    logic [DW-1:0] m_fb [N];
    logic [DW-1:0] m_cmd [N];
    logic [N-1:0] m_dis, m_trip;
    logic         m_ovr, m_done;
    bit           scan_active, m_busy;
    int           cyc, acc_edge, k_eval;

    function automatic int mag(input logic [DW-1:0] x);
        int v;
        v = x;
        return (v >= 32768) ? v - 32768 : 32768 - v;
    endfunction

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_dis = '0; m_ovr = 1'b0; m_done = 1'b0; scan_active = 0; cyc = 0; acc_edge = 0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_fb[i] = '0; m_cmd[i] = '0;
            end
        end else begin
            cyc++;
            m_trip = '0;
            m_done = 1'b0;
            m_busy = scan_active;
            if (scan_active) begin
                k_eval = cyc - acc_edge - 2;
                if (k_eval >= 0 && k_eval < N) begin
                    if (mag(m_fb[k_eval]) > 2 * mag(m_cmd[k_eval]) + int'(TOLV)) begin
                        m_cnt[k_eval] = (m_cnt[k_eval] < TRIP) ? m_cnt[k_eval] + 1 : TRIP;
                        if (m_cnt[k_eval] == TRIP) begin
                            m_dis[k_eval] = 1'b1;
                            m_trip[k_eval] = 1'b1;
                        end
                    end else begin
                        m_cnt[k_eval] = 0;
                    end
                end
                if (cyc == acc_edge + N + 1) begin
                    m_done = 1'b1;
                    scan_active = 0;
                end
            end
            if (reg_wen && reg_waddr == CLR) begin
                for (int i = 0; i < N; i++) begin
                    if (reg_wdata[i] && !m_trip[i]) begin
                        m_cnt[i] = 0;
                        m_dis[i] = 1'b0;
                    end
                end
                if (reg_wdata[31]) m_ovr = 1'b0;
            end
            if (sample_valid) begin
                if (m_busy) begin
                    m_ovr = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        m_fb[i]  = cur_fb[i*DW +: DW];
                        m_cmd[i] = cur_cmd[i*DW +: DW];
                    end
                    acc_edge = cyc;
                    scan_active = 1;
                end
            end
        end
    end

    always @(negedge sysclk) begin
        #1;
        chk("cyc amp_disable", 32'(amp_disable), 32'(m_dis));
        chk("cyc overrun", 32'(overrun), 32'(m_ovr));
        chk("cyc scan_done", 32'(scan_done), 32'(m_done));
        chk("cyc reg_rdata", reg_rdata, (32'(m_ovr) << 31) | 32'(m_dis));
    end

    logic [N*DW-1:0] alt_fb, alt_cmd;
    int lat;

    task automatic set_all(input logic [15:0] fb, input logic [15:0] cmd);
        for (int i = 0; i < N; i++) begin
            cur_fb[i*DW +: DW]  = fb;
            cur_cmd[i*DW +: DW] = cmd;
        end
    endtask

    task automatic set_ch(input int i, input logic [15:0] fb, input logic [15:0] cmd);
        cur_fb[i*DW +: DW]  = fb;
        cur_cmd[i*DW +: DW] = cmd;
    endtask

    // Strobe once; optionally re-strobe with alt data at step extra_k and
    // issue a clear write at step clr_k. lat = cycles until scan_done, -1 on timeout.
    task automatic strobe_wait(input int extra_k, input int clr_k,
                               input logic [31:0] clr_data, output int lat_o);
        @(negedge sysclk);
        sample_valid = 1'b1;
        lat_o = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sysclk);
            sample_valid = (k == extra_k);
            if (k == extra_k) begin
                cur_fb  = alt_fb;
                cur_cmd = alt_cmd;
            end
            reg_wen   = (k == clr_k);
            reg_waddr = CLR;
            reg_wdata = clr_data;
            if (scan_done) begin
                lat_o = k;
                break;
            end
        end
        sample_valid = 1'b0;
        reg_wen = 1'b0;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge sysclk);
        reg_wen = 1'b1; reg_waddr = a; reg_wdata = d;
        @(negedge sysclk);
        reg_wen = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("reset amp_disable", 32'(amp_disable), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset scan_done", 32'(scan_done), 32'h0);
        chk("reset reg_rdata", reg_rdata, 32'h0);
        reset = 1'b0;

        set_all(16'h9000, 16'h8800);
        for (int s = 0; s < 10; s++) begin
            strobe_wait(0, 0, 32'h0, lat);
            chk("nofault latency", 32'(lat), 32'd6);
        end
        chk("nofault amp", 32'(amp_disable), 32'h0);

        set_ch(2, 16'hC000, 16'h8100);
        for (int s = 0; s < 3; s++) begin
            strobe_wait(0, 0, 32'h0, lat);
            chk("pretrip amp", 32'(amp_disable), 32'h0);
        end
        set_all(16'h9000, 16'h8800);
        strobe_wait(0, 0, 32'h0, lat);
        chk("clean sample amp", 32'(amp_disable), 32'h0);

        set_ch(2, 16'hC000, 16'h8100);
        for (int s = 0; s < 4; s++) begin
            strobe_wait(0, 0, 32'h0, lat);
            chk("trip amp", 32'(amp_disable), (s == 3) ? 32'h4 : 32'h0);
        end
        chk("trip rdata", reg_rdata, 32'h4);
        reg_write(16'h0008, 32'h4);
        chk("wrong addr amp", 32'(amp_disable), 32'h4);
        reg_write(CLR, 32'h4);
        chk("clear amp", 32'(amp_disable), 32'h0);
        chk("clear rdata", reg_rdata, 32'h0);

        for (int s = 0; s < 3; s++) strobe_wait(0, 0, 32'h0, lat);
        strobe_wait(0, 4, 32'h4, lat);
        chk("race amp", 32'(amp_disable), 32'h4);
        chk("race latency", 32'(lat), 32'd6);
        reg_write(CLR, 32'h4);
        chk("post race clear", 32'(amp_disable), 32'h0);

        for (int s = 0; s < 3; s++) strobe_wait(0, 0, 32'h0, lat);
        alt_fb = cur_fb;
        alt_cmd = cur_cmd;
        set_all(16'h9000, 16'h8800);
        strobe_wait(2, 0, 32'h0, lat);
        chk("overrun flag", 32'(overrun), 32'h1);
        chk("overrun rdata31", 32'(reg_rdata[31]), 32'h1);
        chk("snapshot kept amp", 32'(amp_disable), 32'h0);
        chk("overrun latency", 32'(lat), 32'd6);
        reg_write(CLR, 32'h8000_0000);
        chk("overrun clear", 32'(overrun), 32'h0);
        chk("overrun clear rdata", reg_rdata, 32'h0);
        strobe_wait(2, 2, 32'h8000_0000, lat);
        chk("overrun clear race", 32'(overrun), 32'h1);
        reg_write(CLR, 32'h8000_0000);

        set_ch(0, 16'h0000, 16'h8000);
        set_ch(1, 16'h8300, 16'h8100);
        set_ch(2, 16'hFFFF, 16'h0000);
        set_ch(3, 16'h7CFF, 16'h8100);
        for (int s = 0; s < 4; s++) strobe_wait(0, 0, 32'h0, lat);
        chk("boundary amp", 32'(amp_disable), 32'h9);

        @(negedge sysclk); sample_valid = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk); sample_valid = 1'b0;
        chk("pre-reset overrun", 32'(overrun), 32'h1);
        chk("pre-reset amp", 32'(amp_disable), 32'h9);
        @(negedge sysclk); reset = 1'b1;
        #1;
        chk("midscan reset amp", 32'(amp_disable), 32'h0);
        chk("midscan reset overrun", 32'(overrun), 32'h0);
        chk("midscan reset rdata", reg_rdata, 32'h0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge sysclk);
            chk("no done after reset", 32'(scan_done), 32'h0);
        end
        set_all(16'h9000, 16'h8800);
        strobe_wait(0, 0, 32'h0, lat);
        chk("post reset latency", 32'(lat), 32'd6);
        chk("post reset amp", 32'(amp_disable), 32'h0);

        @(negedge sysclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
